// File: rtl/lrf_pkg.sv
// Shared constants and helpers for the fusion stream stages.
package lrf_pkg;

    localparam int unsigned DEFAULT_PIXELS_PER_BEAT = 16;
    localparam int unsigned DEFAULT_INPUT_WIDTH     = 8;
    localparam int unsigned DEFAULT_IMAGE_DIM       = 512;
    localparam int unsigned FUSION_PIPE_LATENCY     = 23;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned span;
        r    = 0;
        span = 1;
        while (span < value) begin
            span = span * 2;
            r    = r + 1;
        end
        return r;
    endfunction

    // Number of beats that make up one square frame.
    function automatic int unsigned beats_per_frame(input int unsigned image_dim,
                                                    input int unsigned pixels_per_beat);
        return (image_dim * image_dim) / pixels_per_beat;
    endfunction

    localparam int unsigned BEATS_PER_FRAME =
        beats_per_frame(DEFAULT_IMAGE_DIM, DEFAULT_PIXELS_PER_BEAT);

endpackage

// File: rtl/fusion_axis_out_if.sv
// AXI4-Stream bundle carrying fused frames out of the fusion pipeline.
interface fusion_axis_out_if #(
    parameter int unsigned DATA_WIDTH = 128
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous show-ahead FIFO; head entry is visible on rd_data whenever not empty.
module sync_fifo_fwft
    import lrf_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;

    // Next storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fusion_axis_out.sv
// Output stage of the fusion pipeline: tracks live pipeline slots, buffers fused
// beats, back-pressures the pipeline via stall and emits frames on AXI4-Stream.
module fusion_axis_out
    import lrf_pkg::*;
#(
    parameter int unsigned PIXELS_PER_BEAT = DEFAULT_PIXELS_PER_BEAT,
    parameter int unsigned INPUT_WIDTH     = DEFAULT_INPUT_WIDTH,
    parameter int unsigned IMAGE_DIM       = DEFAULT_IMAGE_DIM,
    parameter int unsigned DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT,
    parameter int unsigned PIPE_LATENCY    = FUSION_PIPE_LATENCY,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  stall,
    input  logic [DATA_WIDTH-1:0] fused_frame,
    fusion_axis_out_if.master     m_axis,
    output logic                  frame_done
);

    localparam int unsigned BEATS   = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int unsigned CNT_W   = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 2;
    localparam int unsigned FCNT_W  = clog2(FIFO_DEPTH) + 1;

    logic [PIPE_LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    frame_done_q, frame_done_d;

    logic                    wr;
    logic                    rd;
    logic                    tvalid;
    logic [ENTRY_W-1:0]      wr_entry;
    logic [ENTRY_W-1:0]      head_entry;
    logic [FCNT_W-1:0]       fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    head_user;
    logic                    head_last;

    // Stall depends only on registered occupancy, never on tready.
    assign stall    = fifo_full;
    assign in_ready = ~stall;
    assign wr       = vld_q[PIPE_LATENCY-1] & ~stall;
    assign tvalid   = (fifo_count != '0);
    assign rd       = tvalid & m_axis.tready;

    // Entry layout: {tuser, tlast, data}.
    assign wr_entry  = {(cnt_q == '0), (cnt_q == CNT_W'(BEATS - 1)), fused_frame};
    assign head_user = head_entry[ENTRY_W-1];
    assign head_last = head_entry[ENTRY_W-2];

    // Stale storage is masked so every stream output reads 0 while nothing is queued.
    assign m_axis.tvalid = tvalid;
    assign m_axis.tdata  = fifo_empty ? '0 : head_entry[DATA_WIDTH-1:0];
    assign m_axis.tuser  = fifo_empty ? 1'b0 : head_user;
    assign m_axis.tlast  = fifo_empty ? 1'b0 : head_last;
    assign frame_done    = frame_done_q;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (aresetn),
        .wr_en   (wr),
        .wr_data (wr_entry),
        .rd_en   (rd),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Valid tracker shifts alongside the fusion pipeline and freezes with it.
    always_comb begin
        vld_d = vld_q;
        if (!stall) begin
            vld_d[0] = in_valid;
            for (int unsigned k = 1; k < PIPE_LATENCY; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // Beat position within the frame, advanced only by real written beats.
    always_comb begin
        cnt_d = cnt_q;
        if (wr) begin
            cnt_d = (cnt_q == CNT_W'(BEATS - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    // End-of-frame pulse follows acceptance of the tlast beat.
    always_comb begin
        frame_done_d = rd & head_last;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_q        <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            cnt_q        <= cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/fusion_axis_out.md
Name: fusion_axis_out

Overview:
- Output stage directly downstream of the fusion pipeline.
- Tracks which pipeline slots carry real beats and captures each fused beat into a small output FIFO.
- Drives the global pipeline stall from FIFO occupancy.
- Emits fused frames as an AXI4-Stream master: tuser marks start of frame, tlast marks end of frame.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per beat.
- INPUT_WIDTH, 8, bits per pixel.
- IMAGE_DIM, 512, frame is IMAGE_DIM x IMAGE_DIM pixels.
- DATA_WIDTH, INPUT_WIDTH*PIXELS_PER_BEAT, beat width.
- PIPE_LATENCY, 23, non-stall cycles from a beat at the fusion inputs to its fused_frame value.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- in_valid  in  1  upstream beat presented to fusion inputs this cycle
- in_ready  out  1  equals ~stall; upstream holds its beat while low
- stall  out  1  freezes the fusion pipeline and this block's valid tracker
- fused_frame  in  DATA_WIDTH  fusion pipeline output
- m_axis_tdata  out  DATA_WIDTH  output beat
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  last beat of frame
- m_axis_tuser  out  1  first beat of frame
- frame_done  out  1  one-cycle pulse when the tlast beat is accepted downstream

Behaviour:
- **Reset:** asynchronous, active-low; reset is a decided requirement. Reset clears the valid tracker, the FIFO pointers and count, and the beat counter. All outputs are 0 in reset except in_ready. in_ready follows ~stall, and stall is 0 when the FIFO is empty, so in_ready reads 1.
- **Valid tracker:** a PIPE_LATENCY-bit shift register, vld[0..PIPE_LATENCY-1].
  - When ~stall: vld[0] <= in_valid and vld[k] <= vld[k-1].
  - When stall: it holds.
  - vld[PIPE_LATENCY-1] high means fused_frame currently holds a real beat.
- **Stall:** stall = (fifo_count == FIFO_DEPTH).
  - Combinational from the registered count only; no path from m_axis_tready.
  - stall stays 1 in a full cycle even if a pop occurs; it drops the next cycle.
- **FIFO write:** wr = vld[PIPE_LATENCY-1] & ~stall.
  - Writes {tuser, tlast, fused_frame} into the FIFO.
  - Overflow is impossible by construction.
- **FIFO read:** rd = m_axis_tvalid & m_axis_tready.
  - Show-ahead FIFO: m_axis_tvalid = (fifo_count != 0), and tdata/tlast/tuser come from the head entry.
  - Simultaneous wr and rd leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **AXI rule:** once tvalid is high, tdata, tlast and tuser stay stable until accepted.
- **Beat counter:** BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; counter width is clog2(BEATS).
  - Increments on each wr.
  - Written tuser = (cnt == 0); written tlast = (cnt == BEATS-1).
  - Wraps to 0 after BEATS-1.
- **frame_done:** registered; 1 in the cycle after rd of an entry with tlast = 1.
- **Pipeline bubbles:** in_valid low produces vld 0 slots. Those slots are never written, and the counter holds.
- **Latency:** with an empty FIFO and m_axis_tready = 1, tvalid rises 1 cycle after the fused beat appears with vld[PIPE_LATENCY-1] = 1. That is PIPE_LATENCY+1 non-stall cycles from in_valid.
- **Reset mid-frame:** in-flight beats and FIFO contents are discarded; the next written beat carries tuser = 1.

Decomposition:
- **Shared package** (lrf_pkg):
  - PIXELS_PER_BEAT, INPUT_WIDTH, IMAGE_DIM defaults.
  - FUSION_PIPE_LATENCY = 23.
  - BEATS_PER_FRAME computation.
  - clog2 function.
- **Sub-module:** one natural sub-module, sync_fifo_fwft (parameters WIDTH, DEPTH). It exposes count, full, empty and show-ahead head data. It is reused by other stream stages.

Test Plan:
- **Reset:** assert aresetn = 0 mid-traffic -> tvalid = 0, tlast = 0, tuser = 0, frame_done = 0, stall = 0 immediately. After release, the first beat carries tuser = 1.
- **Basic frame:** IMAGE_DIM = 8, PPB = 16 (BEATS = 4), PIPE_LATENCY = 23, tready = 1; feed 4 beats with fused_frame = beat index.
  - tvalid first rises 24 cycles after the first in_valid.
  - Data 0,1,2,3 appear with tuser on beat 0 and tlast on beat 3.
  - frame_done pulses once.
- **Backpressure:** FIFO_DEPTH = 4, tready = 0, continuous in_valid -> stall asserts in the cycle count reaches 4 and the tracker freezes.
  - Raising tready drains beats in order with no loss or duplication.
  - The first refill write occurs the cycle after stall drops.
- **Bubbles:** in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 beats out in order, counter advances by 4, and tlast falls on the 4th.
- **Simultaneous push/pop at full:** count = 4 with tready = 1 -> stall = 1 that cycle and count = 3 next. The next cycle does a concurrent write and read, and count stays 3.
- **Frame wrap:** 3 back-to-back frames -> tuser every 4th beat starting at 0, tlast on beats 3, 7, 11, and three frame_done pulses.
